// File: rtl/dot_pipe.sv
// dot_pipe: three-stage fixed-point dot product between FIFOs.
// Products, floored partial sum, then range-checked output register.
module dot_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int Q_BITS     = 16,
   parameter int N          = 3,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] x [N-1:0],
   input  logic signed [DATA_WIDTH-1:0] y [N-1:0],
   input  logic                         in_empty,
   output logic                         in_rd_en,
   output logic        [DATA_WIDTH-1:0] out,
   output logic                         out_ovf,
   input  logic                         out_full,
   output logic                         out_wr_en
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int SW = 2 * DATA_WIDTH + $clog2(N) + 1;
   localparam int TW = SW - DATA_WIDTH + 1;

   logic signed [PW-1:0]         r_prod [N-1:0];
   logic signed [PW-1:0]         w_prod [N-1:0];
   logic signed [SW-1:0]         r_sum;
   logic signed [SW-1:0]         w_sum;
   logic                         r_v1;
   logic                         r_v2;
   logic                         r_v3;
   logic                         w_stall;
   logic                         w_ovf;
   logic        [TW-1:0]         w_top;
   logic        [DATA_WIDTH-1:0] w_res;

   // Only a valid result blocked by a full downstream FIFO freezes the pipe.
   assign w_stall   = r_v3 & out_full;
   assign in_rd_en  = ~in_empty & ~w_stall;
   assign out_wr_en = r_v3 & ~out_full;

   // Full-precision products of the element pairs at the FIFO head.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_prod[i] = PW'(x[i]) * PW'(y[i]);
      end
   end

   // Floor each product back to Q format, then sum wide enough to never wrap.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < N; i++) begin
         w_sum = w_sum + SW'(r_prod[i] >>> Q_BITS);
      end
   end

   // Sum fits only if every bit from the result sign bit upward agrees.
   assign w_top = r_sum[SW-1:DATA_WIDTH-1];
   assign w_ovf = ~((&w_top) | ~(|w_top));

   // Clamp to the nearest bound or keep the low bits, depending on mode.
   always_comb begin
      w_res = r_sum[DATA_WIDTH-1:0];
      if (w_ovf && SATURATE) begin
         if (r_sum[SW-1]) begin
            w_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         end else begin
            w_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         end
      end
   end

   // Valid bits advance together unless stalled; bubbles are kept.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else if (!w_stall) begin
         r_v1 <= in_rd_en;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
      end
   end

   // Product and sum registers follow the valid pipeline.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            r_prod[i] <= '0;
         end
         r_sum <= '0;
      end else if (!w_stall) begin
         for (int i = 0; i < N; i++) begin
            r_prod[i] <= w_prod[i];
         end
         r_sum <= w_sum;
      end
   end

   // Output register loads only real results so it stays put across bubbles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out     <= '0;
         out_ovf <= 1'b0;
      end else if (!w_stall && r_v2) begin
         out     <= w_res;
         out_ovf <= w_ovf;
      end
   end

endmodule

// File: doc/dot_pipe.md
# dot_pipe

Parametrised, fully pipelined fixed-point dot product engine that replaces the single-result, two-state dot unit in the FIFO math library. It pops N-element signed Qm.Q_BITS vector pairs from an upstream FIFO at up to one pair per clock and pushes one DATA_WIDTH-bit result per pair into a downstream FIFO. It adds selectable saturation, a per-result overflow flag, and full backpressure handling. It sits between operand FIFOs and result FIFOs in the ray-intersection datapath.

## Interface
- DATA_WIDTH, 32: width of each operand element and of the result, signed two's complement.
- Q_BITS, 16: number of fractional bits, shared by operands and result.
- N, 3: vector length. Legal range is 1..16.
- SATURATE, 1: 1 clamps the result on overflow; 0 wraps by keeping the low DATA_WIDTH bits.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all pipeline state.
- x  in  DATA_WIDTH × [N-1:0] (unpacked)  operand vector A, read from the head of the upstream FIFO.
- y  in  DATA_WIDTH × [N-1:0] (unpacked)  operand vector B, read from the same FIFO entry as x.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pop request to the upstream FIFO; x and y are captured in the same cycle.
- out  out  DATA_WIDTH  registered result; drives the downstream FIFO din.
- out_ovf  out  1  registered flag; 1 means the result for this entry overflowed.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  push strobe to the downstream FIFO.

## Operation
- Pipeline stages:
  - S1 registers the N full-precision products x[i]*y[i], each 2·DATA_WIDTH bits.
  - S2 registers the sum. Each product is first arithmetic-shifted right by Q_BITS, which floors toward −∞. The sum is then formed at width 2·DATA_WIDTH+$clog2(N)+1, so no intermediate overflow is possible.
  - S3 is the output register. It holds out, out_ovf, and valid bit v3.
- Each stage has a valid bit: v1, v2, v3.
- Range handling: ovf = 1 when the S2 sum lies outside [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - SATURATE=1: out takes the nearest bound.
  - SATURATE=0: out takes sum[DATA_WIDTH−1:0].
  - out_ovf = ovf in both modes.
- Stall: stall = v3 & out_full. While stall=1, every stage register and valid bit holds its value.
- Bubbles are not compressed: a stall freezes empty stages too.
- in_rd_en = !in_empty & !stall. This is combinational; the pop and the S1 capture happen on the same edge.
- out_wr_en = v3 & !out_full. This is combinational. When it is asserted, S3 either advances or clears v3 on the same edge.
- Results leave strictly in input order. None is dropped or duplicated.
- No FSM beyond the valid-bit pipeline; the block is always accepting unless stalled.

## Timing
- Reset values: out=0, out_ovf=0, v1=v2=v3=0. Hence out_wr_en=0. in_rd_en follows !in_empty immediately after reset.
- Latency: a pair popped in cycle t (in_rd_en=1) produces out_wr_en=1 in cycle t+3 if out_full=0.
- Throughput: one result per cycle with in_empty=0 and out_full=0.
- out_full rising while v3=1:
  - out_wr_en=0 and in_rd_en=0 in the same cycle.
  - out holds stable until the first cycle with out_full=0, when out_wr_en=1.
- out_full=1 with v3=0: there is no stall. The pipeline keeps filling until a valid entry reaches S3.
- in_empty=1: a bubble enters S1 (v1=0). The downstream side keeps draining.
- Simultaneous pop and push in one cycle are required and legal.
- Reset asserted mid-operation:
  - All in-flight results are discarded. They are never written.
  - Outputs return to reset values asynchronously.
  - The first pop after deassertion behaves as from power-up.

## Test plan
- Basic, N=3, Q16: x=(0x00010000, 0x00020000, 0x00030000), y=(0x00010000 ×3) -> out=0x00060000, out_ovf=0, out_wr_en exactly 3 cycles after in_rd_en.
- Floor rounding: x=(0xFFFFFFFF ×3), y=(0x00000001 ×3) -> each product −1>>>16 = −1, so out=0xFFFFFFFD.
- Overflow, SATURATE=1: x=(0x01000000, 0, 0), y=(0x01000000, 0, 0) -> out=0x7FFFFFFF, out_ovf=1. Negated x gives out=0x80000000, out_ovf=1.
- Overflow, SATURATE=0, same stimulus -> out=0x00000000, out_ovf=1.
- Backpressure: stream 8 pairs with results 1.0..8.0 (0x00010000..0x00080000), hold out_full=1 for cycles 4–9 -> in_rd_en=0 and out stable throughout the stall; all 8 results written in order, no duplicates.
- Reset mid-stream: assert reset with v1..v3 all set -> out_wr_en drops immediately, out=0; after release, the next pair 0x00010000·0x00010000 (N=1) yields out=0x00010000 as the first write.
